// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment scan driver: segment table,
// blank pattern and the index-width helper.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low patterns, seg[6]=a ... seg[0]=g, indexed by hex nibble
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic logic [6:0] decode(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_scan_driver_scan_timer.sv
// Slot prescaler and digit index counter for the scan driver.
module scan_timer
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int IDX_W       = (N_DIGITS > 1) ? clog2(N_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick,
    output logic [IDX_W-1:0] index,
    output logic             frame_wrap
);

    localparam int CNT_W = clog2(REFRESH_DIV);

    logic [CNT_W-1:0] count;

    assign tick = (count == CNT_W'(REFRESH_DIV - 1));

    // Level signal: high for the whole final slot of a frame
    assign frame_wrap = (index == IDX_W'(N_DIGITS - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            index <= '0;
        end else begin
            if (tick) begin
                count <= '0;
                if (frame_wrap) begin
                    index <= '0;
                end else begin
                    index <= index + IDX_W'(1);
                end
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed seven-segment driver with double-buffered frame data so a
// load never tears the frame currently being scanned.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS    = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int LZ_BLANK    = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp_n,
    output logic [N_DIGITS-1:0]     an,
    output logic                    frame_done
);

    localparam int IDX_W = (N_DIGITS > 1) ? clog2(N_DIGITS) : 1;

    logic                  tick;
    logic                  frame_wrap;
    logic                  boundary;
    logic [IDX_W-1:0]      index;

    logic [4*N_DIGITS-1:0] pend_value, act_value;
    logic [N_DIGITS-1:0]   pend_dp, act_dp;
    logic [N_DIGITS-1:0]   pend_en, act_en;
    logic                  pend_flag;

    logic [N_DIGITS-1:0]   lz_mask;
    logic [3:0]            nib;
    logic [6:0]            seg_next;
    logic                  dp_n_next;
    logic [N_DIGITS-1:0]   an_next;

    scan_timer #(
        .N_DIGITS   (N_DIGITS),
        .REFRESH_DIV(REFRESH_DIV),
        .IDX_W      (IDX_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .index     (index),
        .frame_wrap(frame_wrap)
    );

    assign boundary = tick && frame_wrap;

    // Commit reads the old pending copy; a coincident load refills pending
    // afterwards, so the later assignment keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_value <= '0;
            pend_dp    <= '0;
            pend_en    <= '0;
            pend_flag  <= 1'b0;
            act_value  <= '0;
            act_dp     <= '0;
            act_en     <= '0;
        end else begin
            if (boundary && pend_flag) begin
                act_value <= pend_value;
                act_dp    <= pend_dp;
                act_en    <= pend_en;
                pend_flag <= 1'b0;
            end
            if (load) begin
                pend_value <= value;
                pend_dp    <= dp;
                pend_en    <= digit_en;
                pend_flag  <= 1'b1;
            end
        end
    end

    // Digit k>0 is a leading zero when it and every higher nibble are zero
    always_comb begin
        lz_mask = '0;
        if (LZ_BLANK != 0) begin
            for (int k = 1; k < N_DIGITS; k++) begin
                lz_mask[k] = ((act_value >> (4 * k)) == '0);
            end
        end
    end

    always_comb begin
        nib       = act_value[4*int'(index) +: 4];
        an_next   = '1;
        seg_next  = SEG_BLANK;
        dp_n_next = 1'b1;
        if (act_en[index] && !lz_mask[index]) begin
            an_next[index] = 1'b0;
            seg_next       = decode(nib);
            dp_n_next      = ~act_dp[index];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= SEG_BLANK;
            dp_n       <= 1'b1;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_next;
            dp_n       <= dp_n_next;
            an         <= an_next;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench: edge-counting reference model, table-driven frames
// and hand-written sequences for boundary and reset corner cases.
module tb_seg7_scan_driver;

    localparam int DIV   = 4;
    localparam int ND    = 4;
    localparam int FRAME = DIV * ND;

    localparam logic [6:0] REF_SEG [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
    };

    logic        clk;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_en;
    logic        load;
    logic [6:0]  seg_m, seg_l;
    logic        dpn_m, dpn_l;
    logic [3:0]  an_m, an_l;
    logic        fd_m, fd_l;

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 0;

    seg7_scan_driver #(.N_DIGITS(ND), .REFRESH_DIV(DIV), .LZ_BLANK(0)) dut (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .digit_en(digit_en),
        .load(load), .seg(seg_m), .dp_n(dpn_m), .an(an_m), .frame_done(fd_m)
    );

    seg7_scan_driver #(.N_DIGITS(ND), .REFRESH_DIV(DIV), .LZ_BLANK(1)) dut_lz (
        .clk(clk), .rst(rst), .value(value), .dp(dp), .digit_en(digit_en),
        .load(load), .seg(seg_l), .dp_n(dpn_l), .an(an_l), .frame_done(fd_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Returns {seg, dp_n, an} for digit k of a frame image
    function automatic logic [11:0] ref_disp(input logic [15:0] v, input logic [3:0] d,
                                             input logic [3:0] en, input int k, input bit lz);
        logic [3:0] a;
        logic [3:0] n;
        bit dark;
        n = 4'(v >> (4 * k));
        dark = !en[k] || (lz && k > 0 && (v >> (4 * k)) == 16'h0);
        a = 4'hF;
        a[k] = 1'b0;
        if (dark) return {7'h7F, 1'b1, 4'hF};
        return {REF_SEG[n], ~d[k], a};
    endfunction

    // Reference model: e_cnt counts clock edges since reset released
    int          e_cnt;
    logic [15:0] m_act_v, m_pend_v;
    logic [3:0]  m_act_d, m_pend_d, m_act_e, m_pend_e;
    bit          m_flag;
    logic [12:0] exp_main, exp_lz;

    always @(posedge clk) begin : model
        int  idx;
        bit  bnd;
        if (rst) begin
            e_cnt = 0;
            m_act_v = '0; m_act_d = '0; m_act_e = '0;
            m_pend_v = '0; m_pend_d = '0; m_pend_e = '0;
            m_flag = 0;
            exp_main = {7'h7F, 1'b1, 4'hF, 1'b0};
            exp_lz   = {7'h7F, 1'b1, 4'hF, 1'b0};
        end else begin
            e_cnt++;
            idx = ((e_cnt - 1) / DIV) % ND;
            bnd = (e_cnt % FRAME) == 0;
            exp_main = {ref_disp(m_act_v, m_act_d, m_act_e, idx, 0), bnd};
            exp_lz   = {ref_disp(m_act_v, m_act_d, m_act_e, idx, 1), bnd};
            if (bnd && m_flag) begin
                m_act_v = m_pend_v; m_act_d = m_pend_d; m_act_e = m_pend_e;
                m_flag = 0;
            end
            if (load) begin
                m_pend_v = value; m_pend_d = dp; m_pend_e = digit_en;
                m_flag = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("model_main", {19'h0, seg_m, dpn_m, an_m, fd_m}, {19'h0, exp_main});
            check("model_lz",   {19'h0, seg_l, dpn_l, an_l, fd_l}, {19'h0, exp_lz});
        end
    end

    task automatic wait_frame_done();
        bit found;
        found = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (fd_m) begin
                found = 1;
                break;
            end
        end
        check("frame_done_seen", 32'(found), 32'd1);
    endtask

    task automatic wait_phase(input int ph);
        for (int i = 0; i < 4 * FRAME; i++) begin
            if ((e_cnt % FRAME) == ph) break;
            @(negedge clk);
        end
        check("phase_sync", 32'(e_cnt % FRAME), 32'(ph));
    endtask

    task automatic apply_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] en);
        if (((e_cnt + 1) % FRAME) == 0) @(negedge clk);
        value = v; dp = d; digit_en = en; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Called at the frame_done sample; checks the first cycle of each slot
    task automatic check_slots(input string tag, input logic [27:0] es, input logic [15:0] ea,
                               input logic [3:0] ed, input logic [27:0] ls, input logic [15:0] la);
        for (int k = 0; k < ND; k++) begin
            @(negedge clk);
            check({tag, "_seg"},    32'(seg_m), 32'(es[7*k +: 7]));
            check({tag, "_an"},     32'(an_m),  32'(ea[4*k +: 4]));
            check({tag, "_dpn"},    32'(dpn_m), 32'(ed[k]));
            check({tag, "_lz_seg"}, 32'(seg_l), 32'(ls[7*k +: 7]));
            check({tag, "_lz_an"},  32'(an_l),  32'(la[4*k +: 4]));
            if (k < ND - 1) repeat (DIV - 1) @(negedge clk);
        end
    endtask

    typedef struct {
        logic [15:0] v;
        logic [3:0]  d;
        logic [3:0]  en;
        logic [27:0] es;
        logic [15:0] ea;
        logic [3:0]  ed;
    } vec_t;

    vec_t vecs [4];

    task automatic applyStimulus();
        int dark_cnt;
        int cnt;
        for (int i = 0; i < 4; i++) begin
            apply_load(vecs[i].v, vecs[i].d, vecs[i].en);
            wait_frame_done();
            check_slots($sformatf("vec%0d", i), vecs[i].es, vecs[i].ea, vecs[i].ed,
                        vecs[i].es, vecs[i].ea);
        end

        // Leading-zero blanking on the LZ instance only
        apply_load(16'h0040, 4'h0, 4'hF);
        wait_frame_done();
        check_slots("lz0040", {7'h01, 7'h01, 7'h4C, 7'h01}, 16'h7BDE, 4'hF,
                    {7'h7F, 7'h7F, 7'h4C, 7'h01}, 16'hFFDE);

        // Two mid-frame loads: current frame untouched, last load wins
        wait_frame_done();
        repeat (5) @(negedge clk);
        value = 16'hABCD; dp = 4'h0; digit_en = 4'hF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        value = 16'hEF00; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (5) @(negedge clk);
        check("midframe_keep_an",  32'(an_m),  32'h7);
        check("midframe_keep_seg", 32'(seg_m), 32'h01);
        wait_frame_done();
        check_slots("ef00", {7'h30, 7'h38, 7'h01, 7'h01}, 16'h7BDE, 4'hF,
                    {7'h30, 7'h38, 7'h01, 7'h01}, 16'h7BDE);

        // Load on the boundary cycle
        wait_phase(4);
        value = 16'h1111; dp = 4'h0; digit_en = 4'hF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        wait_phase(FRAME - 1);
        value = 16'h7777; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        check("bnd_frame_done", 32'(fd_m), 32'd1);
        cnt = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) check("bnd_old_pending", 32'(seg_m), 32'h4F);
            if (fd_m) break;
        end
        check("bnd_frame_len", 32'(cnt), 32'(FRAME));
        @(negedge clk);
        check("bnd_new_pending", 32'(seg_m), 32'h0F);

        // Reset mid-frame with a pending load
        wait_phase(4);
        value = 16'h9999; dp = 4'hF; digit_en = 4'hF; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_an",  32'(an_m),  32'hF);
        check("rst_mid_seg", 32'(seg_m), 32'h7F);
        rst = 1'b0;
        dark_cnt = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (seg_m != 7'h7F || an_m != 4'hF) dark_cnt++;
        end
        check("rst_pending_dropped", 32'(dark_cnt), 32'd0);

        // Randomised loads against the reference model
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 11) == 0) begin
                value    = 16'($urandom) >> (4 * $urandom_range(0, 3));
                dp       = 4'($urandom);
                digit_en = ($urandom_range(0, 1) == 0) ? 4'hF : 4'($urandom);
                load     = 1'b1;
            end else begin
                load = 1'b0;
            end
            @(negedge clk);
        end
        load = 1'b0;
    endtask

    task automatic checkOutput();
        check("reset_seg", 32'(seg_m), 32'h7F);
        check("reset_dpn", 32'(dpn_m), 32'h1);
        check("reset_an",  32'(an_m),  32'hF);
        check("reset_fd",  32'(fd_m),  32'h0);
    endtask

    initial begin
        vecs[0] = '{16'h1234, 4'b0000, 4'hF, {7'h4F, 7'h12, 7'h06, 7'h4C}, 16'h7BDE, 4'b1111};
        vecs[1] = '{16'h5A0F, 4'b0010, 4'b1010, {7'h24, 7'h7F, 7'h01, 7'h7F}, 16'h7FDF, 4'b1101};
        vecs[2] = '{16'h8BE9, 4'b1111, 4'hF, {7'h00, 7'h60, 7'h30, 7'h04}, 16'h7BDE, 4'b0000};
        vecs[3] = '{16'hC7D6, 4'b0101, 4'b0111, {7'h7F, 7'h0F, 7'h42, 7'h20}, 16'hFBDE, 4'b1010};

        rst = 1'b1; load = 1'b0; value = '0; dp = '0; digit_en = '0;
        repeat (3) @(negedge clk);
        checkOutput();
        rst = 1'b0;
        chk_en = 1;
        applyStimulus();
        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
